// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encodings, timing defaults,
// and the odd-parity helper.
package ps2_host_tx_pkg;

  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_START_TIMEOUT  = 750000;
  localparam int PS2_BIT_TIMEOUT    = 100000;
  localparam int PS2_FILTER_LEN     = 8;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_INHIBIT = 4'd1;
  localparam logic [3:0] ST_RTS     = 4'd2;
  localparam logic [3:0] ST_DATA    = 4'd3;
  localparam logic [3:0] ST_PARITY  = 4'd4;
  localparam logic [3:0] ST_STOP    = 4'd5;
  localparam logic [3:0] ST_ACK_REL = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
  localparam logic [3:0] ST_ERR     = 4'd8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchronises one raw PS/2 line, accepts a new level only after it has held for
// FILTER_LEN cycles, and strobes fall for one cycle on an accepted 1->0 change.
module ps2_host_tx_line_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines float high, so everything resets to the released level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out 8 data bits,
// parity and stop on device clock falls, then check the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int BIT_TIMEOUT    = PS2_BIT_TIMEOUT,
  parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, BIT_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] INH_PRE    = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(BIT_TIMEOUT);

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;
  logic             clk_level, clk_fall;
  logic             dat_level, dat_fall_unused;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock (clock),
    .resetn(resetn),
    .raw   (ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clock (clock),
    .resetn(resetn),
    .raw   (ps2_dat_i),
    .level (dat_level),
    .fall  (dat_fall_unused)
  );

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign tx_done  = (state == ST_DONE);
  assign tx_error = (state == ST_ERR);

  // cnt doubles as the inhibit timer and the device watchdog; it is reloaded on
  // every state that uses it, so it never wraps.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            state      <= ST_INHIBIT;
            cnt        <= '0;
            bit_idx    <= '0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == INH_PRE) ps2_dat_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            state      <= ST_RTS;
            cnt        <= START_LOAD;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          state      <= ST_IDLE;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
        default: begin
          // Watched states (RTS..ACK_REL); a fall takes priority over expiry.
          if (state == ST_ACK_REL && clk_level && dat_level) begin
            state <= ST_DONE;
          end else if (clk_fall) begin
            cnt <= BIT_LOAD;
            case (state)
              ST_RTS: begin
                ps2_dat_oe <= ~shreg[0];
                bit_idx    <= 4'd1;
                state      <= ST_DATA;
              end
              ST_DATA: begin
                ps2_dat_oe <= ~shreg[0];
                bit_idx    <= bit_idx + 4'd1;
                if (bit_idx == 4'd8) state <= ST_PARITY;
              end
              ST_PARITY: begin
                ps2_dat_oe <= 1'b0;
                bit_idx    <= bit_idx + 4'd1;
                state      <= ST_STOP;
              end
              ST_STOP: begin
                bit_idx <= bit_idx + 4'd1;
                state   <= dat_level ? ST_ERR : ST_ACK_REL;
              end
              default: ;
            endcase
          end else if (cnt < CNT_W'(2)) begin
            state      <= ST_ERR;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Bit 0 of the shift register is always the next bit to present; parity sits above data.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && tx_valid)
      shreg <= {odd_parity(tx_data), tx_data};
    else if (clk_fall && (state == ST_RTS || state == ST_DATA))
      shreg <= {1'b0, shreg[8:1]};
  end

endmodule
